ex_seq_ctrl: RTL and testbench

- Execute-stage sequencer for the pipelined CPU. It detects a multiply in EX, starts the fixed-latency multiplier, and freezes IF/ID/EX for the multiply's duration.
- It then steers the multiplier result into the EX/MEM latch for one cycle.
- It sits beside the ALU controller and consumes its 4-bit ALU control code.

---
 rtl/ex_seq_pkg.sv | 18 +
 rtl/ex_seq_ctrl_sat_counter.sv | 16 +
 rtl/ex_seq_ctrl.sv | 82 ++++++++
 tb/tb_ex_seq_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ex_seq_pkg.sv
// ex_seq_pkg: ALU control codes and sequencer state encoding shared by the EX-stage sequencer.
package ex_seq_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;
  function automatic logic is_mul(input logic [3:0] code);
    return code == ALU_MUL;
  endfunction
endpackage

// File: rtl/ex_seq_ctrl_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones; synchronous active-high clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_cnt <= '0;
    else if (inc_i && r_cnt != '1) r_cnt <= r_cnt + W'(1);
  end
  assign cnt_o = r_cnt;
endmodule

// File: rtl/ex_seq_ctrl.sv
// ex_seq_ctrl: EX-stage multiply sequencer; stalls the front end for MUL_CYCLES and steers the product into EX/MEM.
// Optional stall-cycle performance counter enabled by defining EX_SEQ_PERF_EN.
module ex_seq_ctrl
  import ex_seq_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic [3:0]  alu_ctrl_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        mdu_start_o,
  output logic        mdu_kill_o,
  output logic        result_sel_o,
  output logic        busy_o,
  output logic [31:0] stall_cnt_o
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);
  seq_state_t       r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             w_detect, w_stall, w_start, w_kill, w_sel, w_busy;
  assign w_detect = ex_valid_i && is_mul(alu_ctrl_i) && !flush_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_stall    = 1'b0;
    w_start    = 1'b0;
    w_kill     = 1'b0;
    w_sel      = 1'b0;
    w_busy     = r_state != IDLE;
    unique case (r_state)
      IDLE: begin
        w_stall = w_detect;
        w_start = w_detect;
        if (w_detect) begin
          w_next     = RUN;
          w_cnt_next = CNT_LOAD;
        end
      end
      RUN: begin
        w_stall = !flush_i;
        w_kill  = flush_i;
        if (flush_i) w_next = IDLE;
        else if (r_cnt == '0) w_next = DRAIN;
        else w_cnt_next = r_cnt - CNT_W'(1);
      end
      DRAIN: begin
        w_sel  = !flush_i;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // reset overrides everything combinationally so nothing leaks during the reset cycle
  assign stall_o      = w_stall && !rst_i;
  assign mdu_start_o  = w_start && !rst_i;
  assign mdu_kill_o   = w_kill && !rst_i;
  assign result_sel_o = w_sel && !rst_i;
  assign busy_o       = w_busy && !rst_i;
`ifdef EX_SEQ_PERF_EN
  sat_counter #(.W(32)) u_perf (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(stall_o),
    .cnt_o(stall_cnt_o)
  );
`else
  assign stall_cnt_o = 32'h0;
`endif
endmodule

// File: tb/tb_ex_seq_ctrl.sv
// tb_ex_seq_ctrl: directed vectors with hand-computed outputs, checked through a scoreboard queue.
module tb_ex_seq_ctrl;
  import ex_seq_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v = 1'b0;
  logic [3:0]  alu = ALU_ADD;
  logic        fl = 1'b0;
  logic        stall, start, kill, sel, busy;
  logic [31:0] scnt;
  typedef struct {
    logic [4:0]  o;
    logic [31:0] c;
    string       n;
  } exp_t;
  exp_t        q[$];
  exp_t        e_m;
  logic [4:0]  act_m;
  int          total = 0;
  int          passed = 0;
  logic [31:0] exp_cnt = 0;
  ex_seq_ctrl #(.MUL_CYCLES(4), .CNT_W(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ex_valid_i(v),
    .alu_ctrl_i(alu),
    .flush_i(fl),
    .stall_o(stall),
    .mdu_start_o(start),
    .mdu_kill_o(kill),
    .result_sel_o(sel),
    .busy_o(busy),
    .stall_cnt_o(scnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e_m   = q.pop_front();
      act_m = {stall, start, kill, sel, busy};
      total++;
      if (act_m === e_m.o && scnt === e_m.c) passed++;
      else $display("FAIL %s: got {stall,start,kill,sel,busy}=%b cnt=%0d, want %b cnt=%0d",
                    e_m.n, act_m, scnt, e_m.o, e_m.c);
    end
  end
  // o = {stall, start, kill, sel, busy}
  task automatic cyc(input logic r, input logic vv, input logic [3:0] a, input logic f,
                     input logic [4:0] o, input string n);
    @(posedge clk);
    #1;
    rst = r;
    v   = vv;
    alu = a;
    fl  = f;
`ifdef EX_SEQ_PERF_EN
    q.push_back('{o, exp_cnt, n});
    exp_cnt = r ? 32'd0 : exp_cnt + {31'd0, o[4]};
`else
    q.push_back('{o, 32'd0, n});
`endif
  endtask
  task automatic one_mul(input string n);
    cyc(0, 1, ALU_MUL, 0, 5'b11000, {n, "_det"});
    cyc(0, 1, ALU_MUL, 0, 5'b10001, {n, "_run1"});
    cyc(0, 1, ALU_MUL, 0, 5'b10001, {n, "_run2"});
    cyc(0, 1, ALU_MUL, 0, 5'b10001, {n, "_run3"});
    cyc(0, 1, ALU_MUL, 0, 5'b00011, {n, "_drain"});
  endtask
  initial begin
    cyc(1, 1, ALU_MUL, 0, 5'b00000, "rst_forced0");
    cyc(1, 0, ALU_ADD, 0, 5'b00000, "rst_hold");
    cyc(0, 1, ALU_ADD, 0, 5'b00000, "idle_add");
    cyc(0, 1, ALU_SUB, 0, 5'b00000, "idle_sub");
    cyc(0, 1, ALU_OR,  0, 5'b00000, "idle_or");
    cyc(0, 0, ALU_MUL, 0, 5'b00000, "idle_mul_invalid");
    one_mul("single");
    cyc(0, 1, ALU_ADD, 0, 5'b00000, "single_idle");
    one_mul("b2b_a");
    one_mul("b2b_b");
    cyc(0, 0, ALU_ADD, 0, 5'b00000, "b2b_idle");
    cyc(0, 1, ALU_MUL, 0, 5'b11000, "flrun_det");
    cyc(0, 1, ALU_MUL, 0, 5'b10001, "flrun_run");
    cyc(0, 1, ALU_MUL, 1, 5'b00101, "flrun_kill");
    cyc(0, 0, ALU_ADD, 0, 5'b00000, "flrun_idle");
    cyc(0, 0, ALU_ADD, 0, 5'b00000, "flrun_nosel");
    cyc(0, 1, ALU_MUL, 1, 5'b00000, "fldet_c0");
    cyc(0, 0, ALU_MUL, 0, 5'b00000, "fldet_c1");
    cyc(0, 1, ALU_MUL, 0, 5'b11000, "fldr_det");
    cyc(0, 1, ALU_MUL, 0, 5'b10001, "fldr_run1");
    cyc(0, 1, ALU_ADD, 0, 5'b10001, "fldr_run2_aluign");
    cyc(0, 1, ALU_MUL, 0, 5'b10001, "fldr_run3");
    cyc(0, 1, ALU_MUL, 1, 5'b00001, "fldr_flush");
    one_mul("fldr_next");
    cyc(0, 0, ALU_ADD, 0, 5'b00000, "fldr_idle");
    cyc(0, 1, ALU_MUL, 0, 5'b11000, "rstmid_det");
    cyc(0, 1, ALU_MUL, 0, 5'b10001, "rstmid_run");
    cyc(1, 1, ALU_MUL, 0, 5'b00000, "rstmid_rst");
    cyc(0, 0, ALU_ADD, 0, 5'b00000, "rstmid_idle");
    one_mul("rstmid_restart");
    cyc(0, 0, ALU_ADD, 0, 5'b00000, "rstmid_end");
    cyc(1, 0, ALU_ADD, 0, 5'b00000, "perf_rst");
    one_mul("perf1");
    one_mul("perf2");
    one_mul("perf3");
    cyc(0, 0, ALU_ADD, 0, 5'b00000, "perf_idle");
    @(posedge clk);
    #1;
    v = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
    end
    @(negedge clk);
    total++;
`ifdef EX_SEQ_PERF_EN
    if (scnt === 32'd12) passed++;
    else $display("FAIL perf_total: got %0d, want 12", scnt);
`else
    if (scnt === 32'd0) passed++;
    else $display("FAIL perf_total: got %0d, want 0", scnt);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
